// File: rtl/req_credit_ctrl.sv
// req_credit_ctrl: request scheduler with a saturating pending-request
// counter, a post-serve cooldown window and a sticky overflow error.
// Requests arrive on env_req; a grant in PEND serves one of them, pulses
// response and starts a HOLD_CYCLES-long cooldown during which grants are
// ignored. An arrival that would push the count past MAX_PEND locks the
// block in ERR until rst.
module req_credit_ctrl #(
  parameter int MAX_PEND    = 4,
  parameter int CNT_W       = 3,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             env_req,
  input  logic             ctrl_grant,
  output logic             req_out,
  output logic             response,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             busy,
  output logic             error,
  output logic             _rt_get
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_COOL = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Cooldown counter must hold HOLD_CYCLES-1; keep at least one bit.
  localparam int COOL_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_PEND);
  localparam logic [COOL_W-1:0] COOL_INIT = COOL_W'(HOLD_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_pend_cnt;
  logic [CNT_W-1:0]  w_pend_next;
  logic [COOL_W-1:0] r_cool_cnt;
  logic [COOL_W-1:0] w_cool_next;
  logic              r_req_out;
  logic              r_response;
  logic              r_busy;
  logic              r_error;

  logic              w_inc;
  logic              w_dec;
  logic              w_ovf;

  // Arrivals count in every state except ERR; serves only happen in PEND.
  assign w_inc = env_req && (r_state != ST_ERR);
  assign w_dec = ctrl_grant && (r_state == ST_PEND);
  // A simultaneous serve frees a slot, so inc+dec at the ceiling is legal.
  assign w_ovf = w_inc && !w_dec && (r_pend_cnt == MAX_CNT);

  // Pending-count update: saturate at MAX_PEND on overflow, net out inc/dec.
  always_comb begin
    w_pend_next = r_pend_cnt;
    if (w_ovf) begin
      w_pend_next = r_pend_cnt;
    end else if (w_inc && !w_dec) begin
      w_pend_next = r_pend_cnt + 1'b1;
    end else if (w_dec && !w_inc) begin
      w_pend_next = r_pend_cnt - 1'b1;
    end
  end

  // Next-state and cooldown-counter logic.
  always_comb begin
    w_state_next = r_state;
    w_cool_next  = r_cool_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_ovf) begin
          w_state_next = ST_ERR;
        end else if (w_inc) begin
          w_state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_ovf) begin
          w_state_next = ST_ERR;
        end else if (w_dec) begin
          w_state_next = ST_COOL;
          w_cool_next  = COOL_INIT;
        end
      end
      ST_COOL: begin
        if (w_ovf) begin
          w_state_next = ST_ERR;
          w_cool_next  = '0;
        end else if (r_cool_cnt == '0) begin
          // Cooldown over: resume serving if anything is still queued.
          w_state_next = (w_pend_next != '0) ? ST_PEND : ST_IDLE;
        end else begin
          w_cool_next = r_cool_cnt - 1'b1;
        end
      end
      ST_ERR: begin
        w_state_next = ST_ERR;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cool_next  = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any cooldown at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pend_cnt <= '0;
      r_cool_cnt <= '0;
      r_req_out  <= 1'b0;
      r_response <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pend_cnt <= w_pend_next;
      r_cool_cnt <= w_cool_next;
      r_req_out  <= (w_state_next == ST_PEND);
      r_response <= w_dec;
      r_busy     <= (w_state_next == ST_COOL);
      r_error    <= (w_state_next == ST_ERR);
    end
  end

  assign req_out  = r_req_out;
  assign response = r_response;
  assign pend_cnt = r_pend_cnt;
  assign busy     = r_busy;
  assign error    = r_error;
  assign _rt_get  = env_req;

endmodule

// File: tb/tb_req_credit_ctrl.sv
// tb_req_credit_ctrl: directed stimulus for req_credit_ctrl, checked every
// cycle against a behavioural model (pending count, remaining cooldown
// cycles, error flag) plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_req_credit_ctrl;

  localparam int MAX_PEND    = 4;
  localparam int CNT_W       = 3;
  localparam int HOLD_CYCLES = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             env_req = 1'b0;
  logic             ctrl_grant = 1'b0;
  logic             req_out;
  logic             response;
  logic [CNT_W-1:0] pend_cnt;
  logic             busy;
  logic             error;
  logic             _rt_get;

  int n_checks = 0;
  int n_pass   = 0;

  req_credit_ctrl #(
    .MAX_PEND   (MAX_PEND),
    .CNT_W      (CNT_W),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .env_req   (env_req),
    .ctrl_grant(ctrl_grant),
    .req_out   (req_out),
    .response  (response),
    .pend_cnt  (pend_cnt),
    .busy      (busy),
    .error     (error),
    ._rt_get   (_rt_get)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a request can be served when there is something
  // pending and no cooldown is running; a serve opens HOLD_CYCLES cycles
  // of cooldown.
  int m_pend = 0;
  int m_cool = 0;
  bit m_err  = 1'b0;
  bit m_resp = 1'b0;
  wire m_serve = !m_err && ctrl_grant && (m_cool == 0) && (m_pend > 0);
  wire m_ovf   = !m_err && env_req && !m_serve && (m_pend == MAX_PEND);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 0; m_cool <= 0; m_err <= 1'b0; m_resp <= 1'b0;
    end else if (!m_err) begin
      if (m_ovf) begin
        m_err <= 1'b1; m_resp <= 1'b0; m_cool <= 0;
      end else begin
        m_pend <= m_pend + (env_req ? 1 : 0) - (m_serve ? 1 : 0);
        m_resp <= m_serve;
        if (m_serve) m_cool <= HOLD_CYCLES;
        else if (m_cool > 0) m_cool <= m_cool - 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_req_out",  32'(req_out),  32'(!m_err && m_cool == 0 && m_pend > 0));
      chk("model_busy",     32'(busy),     32'(!m_err && m_cool > 0));
      chk("model_response", 32'(response), 32'(m_resp));
      chk("model_error",    32'(error),    32'(m_err));
      chk("model_pend_cnt", 32'(pend_cnt), 32'(m_pend));
      chk("model_rt_get",   32'(_rt_get),  32'(env_req));
    end
  end

  // Apply inputs for one posedge; returns 1ns after that edge.
  task automatic step(input logic er, input logic gr);
    env_req = er; ctrl_grant = gr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    env_req = 1'b0; ctrl_grant = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_out"},  32'(req_out),  32'd0);
    chk({tag, "_response"}, 32'(response), 32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_error"},    32'(error),    32'd0);
    chk({tag, "_pend_cnt"}, 32'(pend_cnt), 32'd0);
  endtask

  int pulse_idx[$];
  int pulse_cnt[$];
  logic [31:0] pat_env;
  logic [31:0] pat_gnt;

  initial begin
    // Reset state
    repeat (2) @(posedge clk); #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // 1: single request -> PEND one cycle later, no error while waiting
    step(1, 0);
    chk("t1_req_out", 32'(req_out), 32'd1);
    chk("t1_pend",    32'(pend_cnt), 32'd1);
    repeat (3) step(0, 0);
    chk("t1_error",   32'(error), 32'd0);
    chk("t1_req_hold", 32'(req_out), 32'd1);

    // 2: serve -> one response pulse, busy for two cycles, then IDLE
    step(0, 1);
    chk("t2_resp1", 32'(response), 32'd1);
    chk("t2_busy1", 32'(busy), 32'd1);
    chk("t2_pend",  32'(pend_cnt), 32'd0);
    step(0, 0);
    chk("t2_resp2", 32'(response), 32'd0);
    chk("t2_busy2", 32'(busy), 32'd1);
    step(0, 0);
    chk("t2_busy3", 32'(busy), 32'd0);
    chk("t2_idle",  32'(req_out), 32'd0);

    // 3: five arrivals overflow; error sticks through grants
    repeat (4) step(1, 0);
    chk("t3_pend4", 32'(pend_cnt), 32'd4);
    step(1, 0);
    chk("t3_error",   32'(error), 32'd1);
    chk("t3_req_out", 32'(req_out), 32'd0);
    chk("t3_pend_sat", 32'(pend_cnt), 32'd4);
    step(0, 1); step(1, 1);
    chk("t3_sticky", 32'(error), 32'd1);
    chk("t3_no_resp", 32'(response), 32'd0);
    do_reset();

    // 4: inc and dec together at the ceiling is not an overflow
    repeat (4) step(1, 0);
    step(1, 1);
    chk("t4_error", 32'(error), 32'd0);
    chk("t4_pend",  32'(pend_cnt), 32'd4);
    chk("t4_busy",  32'(busy), 32'd1);
    chk("t4_resp",  32'(response), 32'd1);
    step(0, 0); step(0, 0);
    chk("t4_back_pend", 32'(req_out), 32'd1);
    do_reset();

    // 5: grant held high with three pending -> pulses three cycles apart
    repeat (3) step(1, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1);
      if (response === 1'b1) begin
        pulse_idx.push_back(i);
        pulse_cnt.push_back(int'(pend_cnt));
      end
    end
    chk("t5_npulses", 32'(pulse_idx.size()), 32'd3);
    if (pulse_idx.size() == 3) begin
      chk("t5_gap1", 32'(pulse_idx[1] - pulse_idx[0]), 32'd3);
      chk("t5_gap2", 32'(pulse_idx[2] - pulse_idx[1]), 32'd3);
      chk("t5_cnt0", 32'(pulse_cnt[0]), 32'd2);
      chk("t5_cnt1", 32'(pulse_cnt[1]), 32'd1);
      chk("t5_cnt2", 32'(pulse_cnt[2]), 32'd0);
    end
    chk("t5_idle", 32'(req_out), 32'd0);
    do_reset();

    // 6: asynchronous reset mid-COOL and mid-ERR, then recovery
    step(1, 0); step(0, 1);
    chk("t6_in_cool", 32'(busy), 32'd1);
    rst = 1'b1; #1;
    chk_all_zero("t6_cool_rst");
    @(posedge clk); #1; rst = 1'b0;
    step(1, 0);
    chk("t6_resume_req", 32'(req_out), 32'd1);
    repeat (4) step(1, 0);
    chk("t6_in_err", 32'(error), 32'd1);
    rst = 1'b1; #1;
    chk_all_zero("t6_err_rst");
    @(posedge clk); #1; rst = 1'b0;
    step(1, 0);
    chk("t6_resume2", 32'(req_out), 32'd1);
    chk("t6_resume2_pend", 32'(pend_cnt), 32'd1);
    do_reset();

    // Mixed directed pattern, checked by the model every cycle
    pat_env = 32'b1011_0010_1101_0001_1110_0100_1011_0111;
    pat_gnt = 32'b0110_1101_0010_1111_0001_1011_0100_1100;
    for (int i = 0; i < 32; i++) step(pat_env[i], pat_gnt[i]);
    repeat (3) step(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
